// File: rtl/audio_dac_serializer_if.sv
// Sample-side handshake between user logic and the DAC serializer.
// master: the sample producer (drives samples, write strobe and flush).
// slave : the serializer (returns FIFO space, fill level and underrun pulse).
//   clear_audio_out_memory  synchronous FIFO flush
//   left/right_channel_audio_out  two's-complement samples
//   write_audio_out         push one stereo pair (ignored while full)
//   audio_out_allowed       FIFO not full
//   fifo_used               stereo pairs currently stored
//   underrun                one-cycle pulse at a frame start with an empty FIFO
interface audio_dac_serializer_if #(
    parameter int AUDIO_WIDTH = 32,
    parameter int FIFO_DEPTH  = 16
);
    logic                          clear_audio_out_memory;
    logic [AUDIO_WIDTH-1:0]        left_channel_audio_out;
    logic [AUDIO_WIDTH-1:0]        right_channel_audio_out;
    logic                          write_audio_out;
    logic                          audio_out_allowed;
    logic [$clog2(FIFO_DEPTH):0]   fifo_used;
    logic                          underrun;

    modport master (
        output clear_audio_out_memory, left_channel_audio_out,
               right_channel_audio_out, write_audio_out,
        input  audio_out_allowed, fifo_used, underrun
    );

    modport slave (
        input  clear_audio_out_memory, left_channel_audio_out,
               right_channel_audio_out, write_audio_out,
        output audio_out_allowed, fifo_used, underrun
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// Transmit-side WM8731 DAC engine. Buffers stereo pairs in a FIFO and shifts
// them out in left-justified format while acting as clock master.
// Ports:
//   CLOCK_50     system clock (only clock)
//   reset_n      asynchronous active-low reset
//   aud          sample handshake (slave side)
//   AUD_BCLK     bit clock, period 2*BCLK_HALF cycles
//   AUD_DACLRCK  word select, 0 = left slot, 1 = right slot
//   AUD_DACDAT   serial data, MSB first, changes on BCLK falling edges
module audio_dac_serializer #(
    parameter int AUDIO_WIDTH = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int BCLK_HALF   = 12
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    audio_dac_serializer_if.slave aud,
    output logic                  AUD_BCLK,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = 2 * AUDIO_WIDTH;
    localparam int TW = $clog2(BCLK_HALF);
    localparam int BW = $clog2(FW);
    localparam logic [TW-1:0] TICK_LAST = TW'(BCLK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FW - 1);
    localparam logic [BW-1:0] BIT_RIGHT = BW'(AUDIO_WIDTH);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

    logic [FW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          allowed_q, allowed_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          bclk_q, bclk_d;
    logic [BW-1:0] bit_q, bit_d, bit_next_s;
    logic          lrck_q, lrck_d;
    logic [FW-1:0] shift_q, shift_d;
    logic          dat_q, dat_d;
    logic          underrun_q, underrun_d;
    logic          tick_wrap_s, fall_s, frame_start_s, empty_s, push_s, pop_s;

    assign tick_wrap_s   = (tick_q == TICK_LAST);
    assign fall_s        = tick_wrap_s & bclk_q;
    assign bit_next_s    = (bit_q == BIT_LAST) ? {BW{1'b0}} : bit_q + BW'(1);
    assign frame_start_s = fall_s & (bit_next_s == {BW{1'b0}});
    assign empty_s       = (count_q == {(AW + 1){1'b0}});
    assign push_s        = aud.write_audio_out & allowed_q & ~aud.clear_audio_out_memory;
    assign pop_s         = frame_start_s & ~empty_s;

    // FIFO pointer and fill-level next state; flush overrides push and pop.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (aud.clear_audio_out_memory) begin
            wr_d    = {AW{1'b0}};
            rd_d    = {AW{1'b0}};
            count_d = {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_d = wr_q + AW'(1);
            end else begin
                wr_d = wr_q;
            end
            if (pop_s) begin
                rd_d = rd_q + AW'(1);
            end else begin
                rd_d = rd_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
        allowed_d = (count_d != DEPTH);
    end

    // Bit clock, frame position and shift register next state.
    always_comb begin
        tick_d     = tick_wrap_s ? {TW{1'b0}} : tick_q + TW'(1);
        bclk_d     = tick_wrap_s ? ~bclk_q : bclk_q;
        bit_d      = bit_q;
        lrck_d     = lrck_q;
        shift_d    = shift_q;
        dat_d      = dat_q;
        underrun_d = 1'b0;
        if (fall_s) begin
            bit_d  = bit_next_s;
            lrck_d = (bit_next_s >= BIT_RIGHT);
            if (frame_start_s) begin
                if (empty_s) begin
                    shift_d    = {FW{1'b0}};
                    underrun_d = 1'b1;
                end else begin
                    shift_d = mem_q[rd_q];
                end
            end else begin
                shift_d = {shift_q[FW-2:0], 1'b0};
            end
            // Present the new MSB in the same falling edge, so the left MSB
            // lines up with the LRCK 1->0 transition.
            dat_d = shift_d[FW-1];
        end else begin
            dat_d = dat_q;
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge CLOCK_50) begin
        if (push_s) begin
            mem_q[wr_q] <= {aud.left_channel_audio_out, aud.right_channel_audio_out};
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_q       <= {AW{1'b0}};
            rd_q       <= {AW{1'b0}};
            count_q    <= {(AW + 1){1'b0}};
            allowed_q  <= 1'b1;
            tick_q     <= {TW{1'b0}};
            bclk_q     <= 1'b0;
            bit_q      <= BIT_LAST;
            lrck_q     <= 1'b0;
            shift_q    <= {FW{1'b0}};
            dat_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            allowed_q  <= allowed_d;
            tick_q     <= tick_d;
            bclk_q     <= bclk_d;
            bit_q      <= bit_d;
            lrck_q     <= lrck_d;
            shift_q    <= shift_d;
            dat_q      <= dat_d;
            underrun_q <= underrun_d;
        end
    end

    assign aud.audio_out_allowed = allowed_q;
    assign aud.fifo_used         = count_q;
    assign aud.underrun          = underrun_q;
    assign AUD_BCLK              = bclk_q;
    assign AUD_DACLRCK           = lrck_q;
    assign AUD_DACDAT            = dat_q;
endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Transmit-side audio engine: accepts stereo sample pairs from user logic over the `write_audio_out`/`audio_out_allowed` handshake, buffers them in a FIFO, and serializes them to the WM8731 codec DAC in left-justified format. The block is the clock master: it generates `AUD_BCLK` and `AUD_DACLRCK` from `CLOCK_50`, and the codec is configured as slave by `avconf`. It sits between tone/sample generators and the codec pins, replacing the DAC half of `Audio_Controller`.

## Interface
Parameters:
- `AUDIO_WIDTH`, 32: bits per channel sample; also BCLKs per channel slot.
- `FIFO_DEPTH`, 16: stereo pairs buffered; power of 2, ≥2.
- `BCLK_HALF`, 12: `CLOCK_50` cycles per BCLK half-period, ≥2.

Ports:
- `CLOCK_50`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear_audio_out_memory`  in  1  synchronous FIFO flush.
- `left_channel_audio_out`  in  AUDIO_WIDTH  left sample, two's complement.
- `right_channel_audio_out`  in  AUDIO_WIDTH  right sample.
- `write_audio_out`  in  1  push one pair; takes effect only while `audio_out_allowed`=1.
- `audio_out_allowed`  out  1  FIFO not full.
- `fifo_used`  out  clog2(FIFO_DEPTH)+1  pairs currently stored.
- `underrun`  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- `AUD_BCLK`  out  1  bit clock to codec.
- `AUD_DACLRCK`  out  1  word select; 0 = left slot, 1 = right slot.
- `AUD_DACDAT`  out  1  serial data, MSB first.

## Operation
- FIFO: 2·AUDIO_WIDTH wide, stores {left,right}. Push = `write_audio_out & audio_out_allowed & ~clear_audio_out_memory`. Writes issued while full are dropped silently.
- Clock generator: `tick` counts 0..BCLK_HALF-1. On wrap, `AUD_BCLK` toggles. A falling event is the cycle in which `AUD_BCLK` goes 1→0.
- Bit counter `bit_cnt`, range 0..2·AUDIO_WIDTH-1, advances by 1 with wrap on each falling event. Reset value is 2·AUDIO_WIDTH-1, so the first falling event is frame start (bit_cnt=0).
- On each falling event, `AUD_DACLRCK` is set to (new bit_cnt ≥ AUDIO_WIDTH).
- Frame start (new bit_cnt = 0):
  - If the FIFO is not empty: pop the head and load the shift register with {L,R}.
  - If the FIFO is empty: load zeros and pulse `underrun`.
- Other falling events: shift register shifts left by 1 with 0 fill.
- `AUD_DACDAT` = shift register MSB, registered, so it changes only on falling events. The left MSB appears in the same BCLK period as the LRCK 1→0 edge (left-justified).
- Clear: `fifo_used`=0 the next cycle. The frame already in the shift register completes unchanged. Clear beats a simultaneous push.
- Push and pop in the same cycle: `fifo_used` is unchanged and data order is preserved. Pop while empty does not move the pointers.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.

## Timing
- Reset values: `AUD_BCLK`=0, `AUD_DACLRCK`=0, `AUD_DACDAT`=0, `underrun`=0, `fifo_used`=0, `audio_out_allowed`=1. Pointers, tick and shift register are 0; bit_cnt = 2·AUDIO_WIDTH-1.
- BCLK period = 2·BCLK_HALF cycles. Frame = 2·AUDIO_WIDTH BCLKs. Sample rate = 50 MHz / (4·BCLK_HALF·AUDIO_WIDTH), ≈32.55 kHz at defaults.
- First BCLK rise occurs at cycle BCLK_HALF after reset release. First falling event (frame start) occurs at cycle 2·BCLK_HALF.
- `fifo_used` and `audio_out_allowed` are registered and update the cycle after a push or pop.
- Write-to-pin latency with an empty FIFO: data appears at the next frame start. There is no bypass.
- `underrun` is high for exactly the frame-start cycle.
- `reset_n` asserted mid-frame: all state returns to reset values immediately (asynchronously). Buffered samples are lost.

## Test plan
Bench uses BCLK_HALF=2, AUDIO_WIDTH=32, FIFO_DEPTH=4, so a frame is 256 cycles.
- Reset, then push L=32'h8000_0001, R=32'h7FFF_FFFE before cycle 4 -> BCLK falls at cycle 4. The serial stream captured on BCLK rising edges is 1,0…0,1 with LRCK=0, then 0,1…1,0 with LRCK=1. `fifo_used` returns 1→0.
- No pushes after reset -> `underrun` pulses at cycles 4, 260 and 516; DACDAT stays 0; LRCK toggles every 128 cycles.
- Push 6 pairs back-to-back with no pop pending -> `audio_out_allowed` falls after the 4th push; pairs 5 and 6 are dropped; `fifo_used`=4. The next four frames carry pairs 1–4 in order.
- Push and frame-start pop in the same cycle with `fifo_used`=2 -> `fifo_used` stays 2, and the data order is verified over the following 3 frames.
- Assert `clear_audio_out_memory` and `write_audio_out` together with `fifo_used`=3 -> `fifo_used`=0 next cycle. The current frame finishes intact; the next frame start raises `underrun`.
- Drop `reset_n` at cycle 100 of a frame -> all outputs go to reset values within the same cycle; after release, the first falling event occurs 4 cycles later.
